mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids and memType codes.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_RESP = 1'b1
    } state_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: bit 0 = cpu, bit 1 = dbg; a tie goes to the port not granted last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT_DBG) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data memory between the CPU and the bootloader; stores complete at grant,
// loads occupy one extra response cycle during which no new request is accepted.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_type,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_type,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    port_e             last_q, last_d;
    port_e             owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;

    // While debug is high the CPU is invisible to the arbiter.
    assign arb_req = {dbg_req, cpu_req & ~debug};

    rr_arb2 u_rr_arb2 (
        .req  (arb_req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= PORT_DBG;
            owner_q <= PORT_CPU;
            addr_q  <= '0;
            type_q  <= MT_B;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        type_d     = type_q;
        cpu_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        dbg_gnt    = 1'b0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_type   = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        busy       = 1'b0;

        // Outputs are forced quiet for as long as reset is held.
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_gnt[0]) begin
                        cpu_gnt   = 1'b1;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        mem_type  = cpu_type;
                        mem_write = cpu_we;
                        mem_read  = !cpu_we;
                        last_d    = PORT_CPU;
                        if (!cpu_we) begin
                            state_d = ST_RD_RESP;
                            owner_d = PORT_CPU;
                            addr_d  = cpu_addr;
                            type_d  = cpu_type;
                        end
                    end else if (arb_gnt[1]) begin
                        dbg_gnt   = 1'b1;
                        mem_addr  = dbg_addr;
                        mem_wdata = dbg_wdata;
                        mem_type  = MT_W;
                        mem_write = dbg_we;
                        mem_read  = !dbg_we;
                        last_d    = PORT_DBG;
                        if (!dbg_we) begin
                            state_d = ST_RD_RESP;
                            owner_d = PORT_DBG;
                            addr_d  = dbg_addr;
                            type_d  = MT_W;
                        end
                    end
                end
                ST_RD_RESP: begin
                    // Memory needs addr[1:0] and type held while it formats the load data.
                    mem_addr = addr_q;
                    mem_type = type_q;
                    busy     = 1'b1;
                    if (owner_q == PORT_CPU) begin
                        cpu_rvalid = 1'b1;
                        cpu_rdata  = mem_rdata;
                    end else begin
                        dbg_rvalid = 1'b1;
                        dbg_rdata  = mem_rdata;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule
